// File: rtl/bus_burst_reader_pkg.sv
// Shared definitions for the burst reader: bus field widths, FSM encoding
// and the burst-size helper.
package bus_burst_reader_pkg;

  localparam int ADDR_W  = 32;
  localparam int WORD_W  = 32;
  localparam int COUNT_W = 9;
  localparam int BSIZE_W = 8;
  localparam int BE_W    = 4;
  localparam int TIMER_W = 10;

  localparam logic [BE_W-1:0] BYTE_EN_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_BEGIN,
    ST_RECEIVE,
    ST_ABORT,
    ST_DONE
  } state_t;

  // Words in the next burst minus one; the 9-bit result is truncated to the
  // 8-bit bus field, so a 256-word burst encodes as 8'hFF.
  function automatic logic [BSIZE_W-1:0] burst_size(input logic [COUNT_W-1:0] remaining,
                                                     input logic [COUNT_W-1:0] max_words);
    logic [COUNT_W-1:0] words;
    words = (remaining < max_words) ? remaining : max_words;
    words = words - COUNT_W'(1);
    return words[BSIZE_W-1:0];
  endfunction

endpackage

// File: rtl/bus_burst_reader_if.sv
// Client and bus signals of the burst reader. The master modport is the
// reader's view; the slave modport is the view of the client/arbiter/slave side.
interface bus_burst_reader_if;
  import bus_burst_reader_pkg::*;

  // client side
  logic               startIn;
  logic [ADDR_W-1:0]  startAddressIn;
  logic [COUNT_W-1:0] wordCountIn;
  logic               busyOut;
  logic               doneOut;
  logic               errorOut;
  logic [WORD_W-1:0]  dataOut;
  logic               dataValidOut;

  // bus side
  logic               requestOut;
  logic               grantIn;
  logic [WORD_W-1:0]  addressDataIn;
  logic               dataValidIn;
  logic               endTransactionIn;
  logic               busErrorIn;
  logic [ADDR_W-1:0]  addressDataOut;
  logic               beginTransactionOut;
  logic               endTransactionOut;
  logic               readNotWriteOut;
  logic [BE_W-1:0]    byteEnablesOut;
  logic [BSIZE_W-1:0] burstSizeOut;

  modport master (
    input  startIn, startAddressIn, wordCountIn,
    output busyOut, doneOut, errorOut, dataOut, dataValidOut,
    output requestOut,
    input  grantIn, addressDataIn, dataValidIn, endTransactionIn, busErrorIn,
    output addressDataOut, beginTransactionOut, endTransactionOut,
    output readNotWriteOut, byteEnablesOut, burstSizeOut
  );

  modport slave (
    output startIn, startAddressIn, wordCountIn,
    input  busyOut, doneOut, errorOut, dataOut, dataValidOut,
    input  requestOut,
    output grantIn, addressDataIn, dataValidIn, endTransactionIn, busErrorIn,
    input  addressDataOut, beginTransactionOut, endTransactionOut,
    input  readNotWriteOut, byteEnablesOut, burstSizeOut
  );

endinterface

// File: rtl/bus_burst_reader.sv
// Bus initiator that reads a block of words as a sequence of read bursts of
// at most MAX_BURST words and streams the returned words to the client.
// Every output is a register; its next value is derived from the next state.
module bus_burst_reader
  import bus_burst_reader_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic clock,
  input  logic reset,
  bus_burst_reader_if.master bus
);

  localparam logic [COUNT_W-1:0] MAX_WORDS   = COUNT_W'(MAX_BURST);
  localparam logic [TIMER_W-1:0] TIMEOUT_CNT = TIMER_W'(TIMEOUT);

  state_t             state, state_d;
  logic [ADDR_W-1:0]  addr, addr_d;
  logic [COUNT_W-1:0] remaining, remaining_d;
  logic [TIMER_W-1:0] timer, timer_d;
  logic               flag, flag_d;
  logic               accept;
  logic               gap;
  logic [WORD_W-1:0]  data_d;
  logic               valid_d;
  logic               busy_d, req_d, done_d, error_d, begin_d, end_d;

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d     = state;
    addr_d      = addr;
    remaining_d = remaining;
    timer_d     = timer;
    flag_d      = flag;
    accept      = 1'b0;
    gap         = 1'b0;
    data_d      = bus.dataOut;
    valid_d     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.startIn) begin
          flag_d = 1'b0;
          if (bus.wordCountIn == '0) begin
            state_d = ST_DONE;
          end else if (bus.startAddressIn[1:0] != 2'b00) begin
            flag_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d      = bus.startAddressIn;
            remaining_d = bus.wordCountIn;
            state_d     = ST_REQUEST;
          end
        end
      end
      // Grant only counts once our own request is visibly high again, so the
      // one-cycle request gap between bursts is never skipped.
      ST_REQUEST: begin
        if (bus.grantIn && bus.requestOut) state_d = ST_BEGIN;
      end
      ST_BEGIN: begin
        timer_d = '0;
        state_d = ST_RECEIVE;
      end
      ST_RECEIVE: begin
        accept = bus.dataValidIn && !bus.busErrorIn && (remaining != '0);
        if (accept) begin
          valid_d     = 1'b1;
          data_d      = bus.addressDataIn;
          remaining_d = remaining - COUNT_W'(1);
          addr_d      = addr + ADDR_W'(4);
          timer_d     = '0;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
        if (bus.busErrorIn) begin
          flag_d  = 1'b1;
          state_d = ST_ABORT;
        end else if (bus.endTransactionIn) begin
          if (remaining_d != '0) begin
            gap     = 1'b1;
            state_d = ST_REQUEST;
          end else begin
            state_d = ST_DONE;
          end
        end else if (!accept && timer == TIMEOUT_CNT) begin
          flag_d  = 1'b1;
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_REQUEST) || (state_d == ST_BEGIN) ||
              (state_d == ST_RECEIVE) || (state_d == ST_ABORT);
    req_d   = ((state_d == ST_REQUEST) || (state_d == ST_BEGIN) ||
               (state_d == ST_RECEIVE)) && !gap;
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_DONE) && flag_d;
    begin_d = (state_d == ST_BEGIN);
    end_d   = (state_d == ST_ABORT);
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Address, word count, timeout counter and error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      remaining <= '0;
      timer     <= '0;
      flag      <= 1'b0;
    end else begin
      addr      <= addr_d;
      remaining <= remaining_d;
      timer     <= timer_d;
      flag      <= flag_d;
    end
  end

  // Registered client and bus outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.busyOut             <= 1'b0;
      bus.doneOut             <= 1'b0;
      bus.errorOut            <= 1'b0;
      bus.dataOut             <= '0;
      bus.dataValidOut        <= 1'b0;
      bus.requestOut          <= 1'b0;
      bus.addressDataOut      <= '0;
      bus.beginTransactionOut <= 1'b0;
      bus.endTransactionOut   <= 1'b0;
      bus.readNotWriteOut     <= 1'b0;
      bus.byteEnablesOut      <= '0;
      bus.burstSizeOut        <= '0;
    end else begin
      bus.busyOut             <= busy_d;
      bus.doneOut             <= done_d;
      bus.errorOut            <= error_d;
      bus.dataOut             <= data_d;
      bus.dataValidOut        <= valid_d;
      bus.requestOut          <= req_d;
      bus.addressDataOut      <= begin_d ? addr : '0;
      bus.beginTransactionOut <= begin_d;
      bus.endTransactionOut   <= end_d;
      bus.readNotWriteOut     <= begin_d;
      bus.byteEnablesOut      <= begin_d ? BYTE_EN_ALL : '0;
      bus.burstSizeOut        <= begin_d ? burst_size(remaining, MAX_WORDS) : '0;
    end
  end

endmodule

// File: tb/tb_bus_burst_reader.sv
// Directed bench for bus_burst_reader with a ROM-style bus slave and an
// auto-granting arbiter model.
module tb_bus_burst_reader;
  import bus_burst_reader_pkg::*;

  localparam int          TIMEOUT = 1023;
  localparam logic [31:0] ROM_KEY = 32'hDEADBEEF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bus_burst_reader_if bus();

  bus_burst_reader #(.MAX_BURST(16), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // slave behaviour: 0 = ROM, 1 = bus error after begin, 2 = silent
  int slave_mode  = 0;
  int grant_delay = 0;

  // Arbiter and ROM slave: drive bus inputs 1 time unit after each edge
  initial begin : slave
    logic [31:0] s_addr;
    int          s_left;
    bit          s_active;
    int          wait_cnt;
    s_addr = '0; s_left = 0; s_active = 1'b0; wait_cnt = 0;
    bus.grantIn = 1'b0; bus.addressDataIn = '0; bus.dataValidIn = 1'b0;
    bus.endTransactionIn = 1'b0; bus.busErrorIn = 1'b0;
    forever begin
      @(posedge clock); #1;
      bus.dataValidIn = 1'b0; bus.endTransactionIn = 1'b0;
      bus.busErrorIn = 1'b0; bus.addressDataIn = '0;
      if (!reset) begin
        s_active = 1'b0; wait_cnt = 0; bus.grantIn = 1'b0;
      end else begin
        if (bus.requestOut) begin
          bus.grantIn = (wait_cnt >= grant_delay);
          wait_cnt++;
        end else begin
          bus.grantIn = 1'b0;
          wait_cnt = 0;
        end
        if (s_active) begin
          case (slave_mode)
            0: begin
              bus.dataValidIn = 1'b1;
              bus.addressDataIn = s_addr ^ ROM_KEY;
              s_addr = s_addr + 32'd4;
              s_left--;
              if (s_left == 0) begin
                bus.endTransactionIn = 1'b1;
                s_active = 1'b0;
              end
            end
            1: begin
              bus.busErrorIn = 1'b1;
              s_active = 1'b0;
            end
            default: s_active = 1'b0;
          endcase
        end
        if (bus.beginTransactionOut) begin
          s_addr   = bus.addressDataOut;
          s_left   = int'(bus.burstSizeOut) + 1;
          s_active = 1'b1;
        end
      end
    end
  end

  // Monitor: record bus and client events on the falling edge
  int          cyc = 0, nbeg = 0, nw = 0, ndone = 0, nend = 0, ngap = 0, nreq = 0, be_bad = 0;
  int          beg_cyc = 0, end_cyc = 0;
  logic [31:0] beg_addr [64];
  logic [7:0]  beg_size [64];
  logic [31:0] words    [512];
  logic        last_err = 1'b0;
  logic        prev_req = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (bus.beginTransactionOut) begin
      if (nbeg < 64) begin
        beg_addr[nbeg] = bus.addressDataOut;
        beg_size[nbeg] = bus.burstSizeOut;
      end
      nbeg++;
      beg_cyc = cyc;
      if (bus.byteEnablesOut != BYTE_EN_ALL || !bus.readNotWriteOut) be_bad++;
    end else if (bus.byteEnablesOut != '0 || bus.readNotWriteOut ||
                 bus.addressDataOut != '0 || bus.burstSizeOut != '0) begin
      be_bad++;
    end
    if (bus.dataValidOut) begin
      if (nw < 512) words[nw] = bus.dataOut;
      nw++;
    end
    if (bus.doneOut) begin
      ndone++;
      last_err = bus.errorOut;
    end
    if (bus.endTransactionOut) begin
      nend++;
      end_cyc = cyc;
    end
    if (prev_req && !bus.requestOut && bus.busyOut) ngap++;
    if (bus.requestOut) nreq++;
    prev_req = bus.requestOut;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int b0 = 0, w0 = 0, d0 = 0, e0 = 0, g0 = 0, r0 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic start_req(input logic [31:0] a, input logic [8:0] n);
    b0 = nbeg; w0 = nw; d0 = ndone; e0 = nend; g0 = ngap; r0 = nreq;
    @(posedge clock); #1;
    bus.startIn = 1'b1; bus.startAddressIn = a; bus.wordCountIn = n;
    @(posedge clock); #1;
    bus.startIn = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int i = 0;
    while (ndone == d0 && i < limit) begin
      @(posedge clock);
      i++;
    end
    check({tag, "_done"}, ndone - d0, 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Words since the last start must be ROM contents of base, base+4, ...
  task automatic check_words(input string tag, input logic [31:0] base, input int count);
    int bad = 0;
    for (int k = 0; k < count; k++)
      if (words[w0 + k] !== ((base + 32'(4 * k)) ^ ROM_KEY)) bad++;
    check({tag, "_count"}, nw - w0, count);
    check({tag, "_order"}, bad, 0);
  endtask

  initial begin
    bus.startIn = 1'b0; bus.startAddressIn = '0; bus.wordCountIn = '0;
    reset = 1'b0;
    repeat (3) @(posedge clock); #1;
    check("rst_req",  32'(bus.requestOut), 0);
    check("rst_busy", 32'(bus.busyOut), 0);
    check("rst_ctl",  32'({bus.doneOut, bus.errorOut, bus.dataValidOut, bus.beginTransactionOut,
                           bus.endTransactionOut, bus.readNotWriteOut, bus.byteEnablesOut,
                           bus.burstSizeOut}), 0);
    check("rst_addr", bus.addressDataOut, 0);
    @(negedge clock) reset = 1'b1;
    repeat (2) @(posedge clock);

    // single short burst
    start_req(32'hF000_0000, 9'd4);
    wait_done("t1", 100);
    check("t1_begins", nbeg - b0, 1);
    check("t1_addr",   beg_addr[b0], 32'hF000_0000);
    check("t1_size",   32'(beg_size[b0]), 3);
    check_words("t1_words", 32'hF000_0000, 4);
    check("t1_err",    32'(last_err), 0);
    check("t1_idle",   32'(bus.busyOut), 0);

    // 40 words split into 16/16/8
    start_req(32'h0000_1000, 9'd40);
    wait_done("t2", 400);
    check("t2_begins", nbeg - b0, 3);
    check("t2_addr0",  beg_addr[b0],     32'h0000_1000);
    check("t2_addr1",  beg_addr[b0 + 1], 32'h0000_1040);
    check("t2_addr2",  beg_addr[b0 + 2], 32'h0000_1080);
    check("t2_size0",  32'(beg_size[b0]),     15);
    check("t2_size1",  32'(beg_size[b0 + 1]), 15);
    check("t2_size2",  32'(beg_size[b0 + 2]), 7);
    check_words("t2_words", 32'h0000_1000, 40);
    check("t2_gaps",   ngap - g0, 2);
    check("t2_err",    32'(last_err), 0);

    // grant withheld for 50 cycles
    grant_delay = 50;
    start_req(32'h0000_2000, 9'd2);
    repeat (40) @(posedge clock);
    #1;
    check("t3_nobegin", nbeg - b0, 0);
    check("t3_reqheld", 32'(bus.requestOut), 1);
    wait_done("t3", 200);
    grant_delay = 0;
    check("t3_begins", nbeg - b0, 1);
    check_words("t3_words", 32'h0000_2000, 2);
    check("t3_err",    32'(last_err), 0);

    // bus error after begin
    slave_mode = 1;
    start_req(32'h0000_3000, 9'd8);
    wait_done("t4", 100);
    slave_mode = 0;
    check("t4_endpulse", nend - e0, 1);
    check("t4_err",      32'(last_err), 1);
    check("t4_nowords",  nw - w0, 0);

    // silent slave -> timeout
    slave_mode = 2;
    start_req(32'h0000_4000, 9'd4);
    wait_done("t5", 1300);
    slave_mode = 0;
    check("t5_endpulse", nend - e0, 1);
    check("t5_err",      32'(last_err), 1);
    check("t5_window",   32'((end_cyc - beg_cyc) >= TIMEOUT && (end_cyc - beg_cyc) <= TIMEOUT + 4), 1);

    // misaligned start address
    start_req(32'h0000_0003, 9'd4);
    wait_done("t6", 20);
    check("t6_err",    32'(last_err), 1);
    check("t6_nobus",  (nbeg - b0) + (nreq - r0), 0);

    // zero word count
    start_req(32'h0000_5000, 9'd0);
    wait_done("t7", 20);
    check("t7_err",    32'(last_err), 0);
    check("t7_nobus",  (nbeg - b0) + (nreq - r0), 0);

    // reset in the middle of a burst
    start_req(32'h0000_6000, 9'd40);
    for (int i = 0; i < 200 && (nw - w0) < 5; i++) @(posedge clock);
    check("t8_midburst", 32'((nw - w0) >= 5), 1);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("t8_ctl",  32'({bus.requestOut, bus.busyOut, bus.doneOut, bus.errorOut, bus.dataValidOut,
                          bus.beginTransactionOut, bus.endTransactionOut, bus.readNotWriteOut,
                          bus.byteEnablesOut, bus.burstSizeOut}), 0);
    check("t8_addr", bus.addressDataOut, 0);
    check("t8_data", bus.dataOut, 0);
    repeat (3) @(posedge clock);
    check("t8_noabort", nend - e0, 0);
    @(negedge clock) reset = 1'b1;
    repeat (2) @(posedge clock);

    start_req(32'h0000_7000, 9'd4);
    wait_done("t9", 100);
    check("t9_begins", nbeg - b0, 1);
    check_words("t9_words", 32'h0000_7000, 4);
    check("t9_err",    32'(last_err), 0);

    check("bus_fields", be_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
